jtbubl_dwnld: RTL
=================

// Module: jtbubl_dwnld
// PURPOSE
//  Upstream loader stage for the Bubble Bobble core. Converts the serial ioctl byte stream into SDRAM
//  write requests (prog_*) and PROM write strobes for the video colour PROMs. Remaps the GFX region so
//  one 32-bit SDRAM read returns a byte from each of the four GFX quarters. Buffers bytes in a
//  2-entry FIFO while the SDRAM controller is slow to acknowledge.
// PARAMETERS
//  SUB_START   25'h2_8000  byte address where the sub CPU ROM starts (main ROM is 0..SUB_START-1)
//  GFX_START   25'h4_0000  byte address where the GFX region starts (512 kB long)
//  PROM_START  25'hC_0000  byte address of the first PROM byte; region is PROM_LEN bytes long
//  PROM_LEN    512         PROM region length in bytes; bytes beyond it are dropped
// PORTS
//  clk          in   1   system clock (all logic on this edge)
//  rst          in   1   synchronous, active-high reset
//  downloading  in   1   high while ioctl transfer active
//  ioctl_addr   in   25  byte address of incoming byte
//  ioctl_data   in   8   incoming byte
//  ioctl_wr     in   1   one-cycle strobe: ioctl_addr/ioctl_data valid
//  prog_addr    out  22  SDRAM word address; low 8 bits carry PROM address during prom_we
//  prog_data    out  8   byte to write; low 4 bits carry PROM nibble during prom_we
//  prog_mask    out  2   byte-lane mask, active low: 2'b10 = low byte, 2'b01 = high byte
//  prog_we      out  1   SDRAM write request; held until sdram_ack
//  prom_we      out  1   one-cycle PROM write pulse
//  sdram_ack    in   1   SDRAM controller accepted current prog_we request
//  dwnld_busy   out  1   downloading | FIFO not empty | prog_we
//  dwnld_ovf    out  1   sticky: a byte was lost to FIFO overflow
// BEHAVIOUR
//  Reset: prog_addr=0, prog_data=0, prog_mask=2'b11, prog_we=0, prom_we=0, dwnld_ovf=0, FIFO empty.
//   Reset mid-transfer discards all pending bytes.
//  Classification (on ioctl_wr):
//   a < GFX_START  -> SDRAM: word = a[22:1], mask = a[0] ? 2'b01 : 2'b10
//   GFX region     -> r = a - GFX_START (19 bits); n = {r[16:0], r[18:17]};
//                     word = (GFX_START>>1) + n[18:1], mask from n[0]
//   PROM region    -> prom_we pulse next cycle, prog_addr[7:0] = a[7:0], prog_data = ioctl_data.
//                     Bypasses the FIFO; does not touch prog_we.
//   a >= PROM_START+PROM_LEN -> dropped silently
//   Regions between GFX end and PROM_START -> linear mapping, same as a < GFX_START.
//  FIFO: 2 entries of {addr 22, data 8, mask 2}.
//   Push on ioctl_wr of an SDRAM-class byte. Push while full: byte dropped, dwnld_ovf set.
//  Output FSM:
//   IDLE: FIFO not empty -> load head into prog_*, prog_we=1, pop -> WAIT.
//   WAIT: sdram_ack=1 -> prog_we=0 -> IDLE (next entry issued one cycle later; no back-to-back
//         requests).
//  Latency: ioctl_wr in cycle n, FIFO empty, IDLE -> prog_we high in cycle n+2.
//   PROM byte -> prom_we high in cycle n+1 only.
//  Simultaneous push and pop: both occur; occupancy unchanged.
//  A PROM byte arriving while in WAIT: prom_we still pulses.
//   prog_addr/prog_data are then overloaded for that one cycle; prog_we stays high.
//   The SDRAM controller samples only its latched request, so this is safe.
//  downloading falling with entries pending: FIFO drains normally; dwnld_busy stays high until empty
//   and idle.
//  sdram_ack while IDLE: ignored.
// STRUCTURE
//  Region constants and the GFX bit-swizzle function go in the shared header jtbubl_mem.vh.
//   jtbubl_game uses the same header for its jtframe_rom slot offsets.
//  Sub-module jtbubl_dwnld_fifo: 2-entry synchronous FIFO with full/empty flags and a drop-on-full
//   push.
//  Top holds the classifier, PROM pulse logic, 2-state output FSM and overflow flag.
// TESTING
//  1. Main byte: a=25'h0_0003, d=8'hA5 -> cycle n+2: prog_we=1, prog_addr=22'h1, prog_mask=2'b01,
//     prog_data=8'hA5.
//  2. GFX remap: a=25'h6_0004 (r=19'h2_0004 -> n=19'h0_0011) -> prog_addr=22'h2_0008, prog_mask=2'b01.
//  3. PROM: a=25'hC_0012, d=8'h0B -> prom_we single pulse at n+1, prog_addr[7:0]=8'h12,
//     prog_data[3:0]=4'hB, prog_we stays 0.
//  4. Backpressure: 3 bytes, 1 cycle apart, sdram_ack held low -> third accepted (one in WAIT, two in
//     FIFO); 4th sets dwnld_ovf=1; releasing ack drains all 3 in order.
//  5. Reset in WAIT with 2 queued -> next cycle prog_we=0, FIFO empty, dwnld_busy=downloading.
//  6. downloading drops with 1 queued -> dwnld_busy stays 1 until that byte is acked, then 0.

Source files
------------

// File: rtl/jtbubl_dwnld_pkg.sv
// Shared region map, FIFO entry type and GFX address remap for the Bubble Bobble loader.
package jtbubl_dwnld_pkg;

   localparam int unsigned AW         = 25;
   localparam int unsigned WW         = 22;
   localparam int unsigned DW         = 8;
   localparam int unsigned MW         = 2;
   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned PROM_LEN   = 512;

   localparam logic [AW-1:0] SUB_START  = 25'h2_8000;
   localparam logic [AW-1:0] GFX_START  = 25'h4_0000;
   localparam logic [AW-1:0] GFX_LEN    = 25'h8_0000;
   localparam logic [AW-1:0] PROM_START = 25'hC_0000;
   localparam logic [AW-1:0] PROM_END   = PROM_START + AW'(PROM_LEN);

   typedef struct packed {
      logic [WW-1:0] addr;
      logic [DW-1:0] data;
      logic [MW-1:0] mask;
   } prog_entry_t;

   typedef enum logic [1:0] {
      REG_SDRAM,
      REG_PROM,
      REG_DROP
   } region_t;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } state_t;

   // Which destination an incoming byte address belongs to
   function automatic region_t classify(input logic [AW-1:0] a);
      if (a >= PROM_END)        return REG_DROP;
      else if (a >= PROM_START) return REG_PROM;
      else                      return REG_SDRAM;
   endfunction

   // Rotate the GFX offset so the two top bits become the byte-lane/word LSBs
   function automatic logic [18:0] gfx_swizzle(input logic [18:0] r);
      return {r[16:0], r[18:17]};
   endfunction

   // SDRAM word address and active-low lane mask for an SDRAM-class byte
   function automatic prog_entry_t map_sdram(input logic [AW-1:0] a, input logic [DW-1:0] d);
      prog_entry_t e;
      logic [18:0] n;
      e.data = d;
      if (a >= GFX_START && a < GFX_START + GFX_LEN) begin
         n      = gfx_swizzle(19'(a - GFX_START));
         e.addr = WW'(GFX_START >> 1) + WW'(n[18:1]);
         e.mask = n[0] ? 2'b01 : 2'b10;
      end else begin
         e.addr = a[22:1];
         e.mask = a[0] ? 2'b01 : 2'b10;
      end
      return e;
   endfunction

endpackage

// File: rtl/jtbubl_dwnld_if.sv
// ioctl input stream plus SDRAM/PROM programming outputs of the loader.
interface jtbubl_dwnld_if;
   import jtbubl_dwnld_pkg::*;

   logic          downloading;
   logic [AW-1:0] ioctl_addr;
   logic [DW-1:0] ioctl_data;
   logic          ioctl_wr;
   logic [WW-1:0] prog_addr;
   logic [DW-1:0] prog_data;
   logic [MW-1:0] prog_mask;
   logic          prog_we;
   logic          prom_we;
   logic          sdram_ack;
   logic          dwnld_busy;
   logic          dwnld_ovf;

   modport master (
      input  downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
      output prog_addr, prog_data, prog_mask, prog_we, prom_we, dwnld_busy, dwnld_ovf
   );

   modport slave (
      output downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
      input  prog_addr, prog_data, prog_mask, prog_we, prom_we, dwnld_busy, dwnld_ovf
   );

endinterface

// File: rtl/jtbubl_dwnld_fifo.sv
// Two-entry synchronous FIFO; a push into a full FIFO is dropped unless a pop frees a slot.
module jtbubl_dwnld_fifo
   import jtbubl_dwnld_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  prog_entry_t din,
   input  logic        pop,
   output prog_entry_t head_c,
   output logic        empty_c,
   output logic        full_c,
   output logic        drop_c
);

   prog_entry_t mem [FIFO_DEPTH];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  count;
   logic        pop_ok;
   logic        push_ok;

   assign empty_c = (count == 2'd0);
   assign full_c  = (count == 2'(FIFO_DEPTH));
   assign pop_ok  = pop && !empty_c;
   assign push_ok = push && (!full_c || pop_ok);
   assign drop_c  = push && !push_ok;
   assign head_c  = mem[rd_ptr];

   // Entry storage, no reset needed: occupancy gates every read
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // Pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) wr_ptr <= ~wr_ptr;
         if (pop_ok)  rd_ptr <= ~rd_ptr;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/jtbubl_dwnld.sv
// ioctl byte stream to SDRAM write requests and colour PROM write strobes.
module jtbubl_dwnld
   import jtbubl_dwnld_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   jtbubl_dwnld_if.master bus
);

   region_t     region_c;
   logic        sdram_hit_c;
   logic        prom_hit_c;
   prog_entry_t entry_c;
   prog_entry_t head_c;
   logic        empty_c;
   logic        full_c;
   logic        drop_c;
   logic        issue_c;
   state_t      state;
   logic [WW-1:0] held_addr;
   logic [DW-1:0] held_data;

   assign region_c    = classify(bus.ioctl_addr);
   assign sdram_hit_c = bus.ioctl_wr && (region_c == REG_SDRAM);
   assign prom_hit_c  = bus.ioctl_wr && (region_c == REG_PROM);
   assign entry_c     = map_sdram(bus.ioctl_addr, bus.ioctl_data);

   // A PROM byte owns prog_addr/prog_data for its cycle, so a new request
   // is held back one cycle rather than launched with an overloaded address.
   assign issue_c = (state == ST_IDLE) && !empty_c && !prom_hit_c;

   jtbubl_dwnld_fifo u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (sdram_hit_c),
      .din     (entry_c),
      .pop     (issue_c),
      .head_c  (head_c),
      .empty_c (empty_c),
      .full_c  (full_c),
      .drop_c  (drop_c)
   );

   // Request FSM, PROM pulse and the shared prog_addr/prog_data bus
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         bus.prog_addr <= '0;
         bus.prog_data <= '0;
         bus.prog_mask <= 2'b11;
         bus.prog_we   <= 1'b0;
         bus.prom_we   <= 1'b0;
         held_addr     <= '0;
         held_data     <= '0;
      end else begin
         bus.prom_we <= prom_hit_c;
         case (state)
            ST_IDLE: begin
               if (issue_c) begin
                  held_addr   <= head_c.addr;
                  held_data   <= head_c.data;
                  bus.prog_we <= 1'b1;
                  state       <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (bus.sdram_ack) begin
                  bus.prog_we <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
         if (prom_hit_c) begin
            bus.prog_addr <= {14'd0, bus.ioctl_addr[7:0]};
            bus.prog_data <= bus.ioctl_data;
         end else if (issue_c) begin
            bus.prog_addr <= head_c.addr;
            bus.prog_data <= head_c.data;
            bus.prog_mask <= head_c.mask;
         end else begin
            // Restore the latched request after a PROM overload cycle
            bus.prog_addr <= held_addr;
            bus.prog_data <= held_data;
         end
      end
   end

   // Sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst)         bus.dwnld_ovf <= 1'b0;
      else if (drop_c) bus.dwnld_ovf <= 1'b1;
   end

   assign bus.dwnld_busy = bus.downloading | !empty_c | bus.prog_we;

   logic unused_c;
   assign unused_c = full_c;

endmodule
